// File: rtl/kcpsmx3_inc.sv
// Shared RojoBlaze ALU definitions: field widths, opcode/shift types,
// stimulus generator modes and the LFSR polynomial.
package kcpsmx3_inc;

    localparam int unsigned OPERAND_WIDTH = 8;
    localparam int unsigned OPCODE_WIDTH  = 5;
    localparam int unsigned NUM_OPCODES   = 24;

    // Galois taps for the 32-bit right-shifting stimulus LFSRs
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    typedef enum logic [2:0] {
        SH_RL  = 3'd0,
        SH_RR  = 3'd1,
        SH_SL0 = 3'd2,
        SH_SL1 = 3'd3,
        SH_SLX = 3'd4,
        SH_SR0 = 3'd5,
        SH_SR1 = 3'd6,
        SH_SRX = 3'd7
    } shift_op_t;

    typedef enum logic [1:0] {
        WEIGHTED = 2'b00,
        UNIFORM  = 2'b01,
        CORNERS  = 2'b10,
        WALKING  = 2'b11
    } gen_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RST   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } stim_state_t;

    // One step of the Galois LFSR
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit Galois LFSR with a zero-safe reset seed and a step enable.
module stim_lfsr32
    import kcpsmx3_inc::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_i,
    output logic [31:0] state_o
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1
    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] state_q;

    // Reseed on reset, advance once per enabled cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED_NZ;
        end else if (step_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alu_stim_gen.sv
// ALU stimulus sequencer: issues run_count LFSR-derived ALU transactions
// over valid/ready, with an optional DUT reset phase beforehand.
module alu_stim_gen #(
    parameter int unsigned OPERAND_WIDTH = kcpsmx3_inc::OPERAND_WIDTH,
    parameter int unsigned OPCODE_WIDTH  = kcpsmx3_inc::OPCODE_WIDTH,
    parameter int unsigned NUM_OPCODES   = kcpsmx3_inc::NUM_OPCODES,
    parameter int unsigned RUN_CNT_WIDTH = 16,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter logic [31:0] SEED          = 32'hACE1_2249
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [RUN_CNT_WIDTH-1:0] run_count,
    input  logic [1:0]               mode,
    input  logic                     reset_dut_req,
    output logic                     dut_reset,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [OPCODE_WIDTH-1:0]  opcode,
    output logic [2:0]               shift_op,
    output logic                     shift_dir,
    output logic                     shift_const,
    output logic                     carry_in,
    output logic [OPERAND_WIDTH-1:0] operand_a,
    output logic [OPERAND_WIDTH-1:0] operand_b,
    output logic                     busy,
    output logic                     done,
    output logic [RUN_CNT_WIDTH-1:0] issued_count
);

    import kcpsmx3_inc::*;

    localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LAST   = RST_CNT_W'(RESET_CYCLES - 1);
    localparam logic [OPCODE_WIDTH:0] NUM_OP_EXT = NUM_OPCODES[OPCODE_WIDTH:0];

    stim_state_t                state_q;
    gen_mode_t                  mode_q;
    logic [RUN_CNT_WIDTH-1:0]   run_cnt_q;
    logic [RUN_CNT_WIDTH-1:0]   issued_count_q;
    logic [RST_CNT_W-1:0]       rst_cnt_q;
    logic [OPERAND_WIDTH-1:0]   walk_q;
    logic                       dut_reset_q, op_valid_q, done_q, busy_q;
    logic [OPCODE_WIDTH-1:0]    opcode_q;
    shift_op_t                  shift_op_q;
    logic                       shift_dir_q, shift_const_q, carry_in_q;
    logic [OPERAND_WIDTH-1:0]   operand_a_q, operand_b_q;

    logic [31:0]                lfsr_a, lfsr_b, lfsr_c;
    logic                       load_c;
    gen_mode_t                  load_mode_c;
    logic [RUN_CNT_WIDTH-1:0]   issued_inc_c;
    logic [OPERAND_WIDTH-1:0]   walk_next_c;
    logic [OPCODE_WIDTH:0]      opcode_ext_c;
    logic [OPERAND_WIDTH-1:0]   operand_a_c, operand_b_c;
    logic                       unused_lfsr_bits;

    // Three independent streams: a/b operands, c control fields
    stim_lfsr32 #(.SEED(SEED)) u_lfsr_a (
        .clk(clk), .reset(reset), .step_i(load_c), .state_o(lfsr_a));
    stim_lfsr32 #(.SEED(SEED ^ 32'h5A5A_5A5A)) u_lfsr_b (
        .clk(clk), .reset(reset), .step_i(load_c), .state_o(lfsr_b));
    stim_lfsr32 #(.SEED(SEED ^ 32'hA5A5_A5A5)) u_lfsr_c (
        .clk(clk), .reset(reset), .step_i(load_c), .state_o(lfsr_c));

    // Bits of the LFSR state that feed no field
    assign unused_lfsr_bits = ^{lfsr_a, lfsr_b, lfsr_c};

    // Operand distribution for the LFSR-driven modes
    function automatic logic [OPERAND_WIDTH-1:0] pick_operand(input logic [31:0] x,
                                                              input gen_mode_t m);
        logic [OPERAND_WIDTH-1:0] r;
        r = x[OPERAND_WIDTH-1:0];
        case (m)
            WEIGHTED: begin
                case (x[31:30])
                    2'b00:   return '0;
                    2'b11:   return OPERAND_WIDTH'(1);
                    default: return r;
                endcase
            end
            CORNERS: begin
                case (x[31:30])
                    2'b00:   return '0;
                    2'b01:   return '1;
                    2'b10:   return OPERAND_WIDTH'(1) << (OPERAND_WIDTH - 1);
                    default: return r;
                endcase
            end
            default: return r;
        endcase
    endfunction

    // Field-load decision and next transaction fields
    always_comb begin
        issued_inc_c = issued_count_q + RUN_CNT_WIDTH'(1);
        load_mode_c  = (state_q == ST_IDLE) ? gen_mode_t'(mode) : mode_q;
        walk_next_c  = (state_q == ST_ISSUE)
                     ? ((walk_q << 1) | (walk_q >> (OPERAND_WIDTH - 1)))
                     : OPERAND_WIDTH'(1);
        load_c = 1'b0;
        case (state_q)
            ST_IDLE:  load_c = start && (run_count != '0) && !reset_dut_req;
            ST_RST:   load_c = !abort && (rst_cnt_q == '0);
            ST_ISSUE: load_c = !abort && op_ready && (issued_inc_c != run_cnt_q);
            default:  load_c = 1'b0;
        endcase

        opcode_ext_c = {1'b0, lfsr_c[OPCODE_WIDTH-1:0]};
        if (opcode_ext_c >= NUM_OP_EXT) begin
            opcode_ext_c = opcode_ext_c - NUM_OP_EXT;
        end

        if (load_mode_c == WALKING) begin
            operand_a_c = walk_next_c;
            operand_b_c = ~walk_next_c;
        end else begin
            operand_a_c = pick_operand(lfsr_a, load_mode_c);
            operand_b_c = pick_operand(lfsr_b, load_mode_c);
        end
    end

    // Run control FSM with registered outputs and transaction fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mode_q         <= WEIGHTED;
            run_cnt_q      <= '0;
            issued_count_q <= '0;
            rst_cnt_q      <= '0;
            walk_q         <= '0;
            dut_reset_q    <= 1'b0;
            op_valid_q     <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            opcode_q       <= '0;
            shift_op_q     <= SH_RL;
            shift_dir_q    <= 1'b0;
            shift_const_q  <= 1'b0;
            carry_in_q     <= 1'b0;
            operand_a_q    <= '0;
            operand_b_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q         <= gen_mode_t'(mode);
                        run_cnt_q      <= run_count;
                        issued_count_q <= '0;
                        busy_q         <= 1'b1;
                        if (run_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (reset_dut_req) begin
                            state_q     <= ST_RST;
                            dut_reset_q <= 1'b1;
                            rst_cnt_q   <= RST_LAST;
                        end else begin
                            state_q    <= ST_ISSUE;
                            op_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RST: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        dut_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (rst_cnt_q == '0) begin
                        state_q     <= ST_ISSUE;
                        dut_reset_q <= 1'b0;
                        op_valid_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RST_CNT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        op_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (op_ready) begin
                        issued_count_q <= issued_inc_c;
                        if (issued_inc_c == run_cnt_q) begin
                            state_q    <= ST_DONE;
                            op_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (load_c) begin
                walk_q        <= walk_next_c;
                opcode_q      <= opcode_ext_c[OPCODE_WIDTH-1:0];
                shift_op_q    <= shift_op_t'(lfsr_c[10:8]);
                shift_dir_q   <= lfsr_c[12];
                shift_const_q <= lfsr_c[13];
                carry_in_q    <= lfsr_c[14];
                operand_a_q   <= operand_a_c;
                operand_b_q   <= operand_b_c;
            end
        end
    end

    assign dut_reset    = dut_reset_q;
    assign op_valid     = op_valid_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign issued_count = issued_count_q;
    assign opcode       = opcode_q;
    assign shift_op     = shift_op_q;
    assign shift_dir    = shift_dir_q;
    assign shift_const  = shift_const_q;
    assign carry_in     = carry_in_q;
    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;

endmodule

// File: tb/tb_alu_stim_gen.sv
// Scoreboard bench for alu_stim_gen: expected transactions come from an
// independent LFSR model and are checked by a handshake monitor.
module tb_alu_stim_gen;

    localparam int W     = 8;
    localparam int OPW   = 5;
    localparam int NUMOP = 24;
    localparam int RCW   = 16;
    localparam int RSTC  = 4;
    localparam logic [31:0] SEED = 32'hACE1_2249;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [RCW-1:0] run_count = '0;
    logic [1:0]     mode = 2'b00;
    logic           reset_dut_req = 1'b0;
    logic           dut_reset;
    logic           op_valid;
    logic           op_ready = 1'b0;
    logic [OPW-1:0] opcode;
    logic [2:0]     shift_op;
    logic           shift_dir, shift_const, carry_in;
    logic [W-1:0]   operand_a, operand_b;
    logic           busy, done;
    logic [RCW-1:0] issued_count;

    alu_stim_gen #(
        .OPERAND_WIDTH(W), .OPCODE_WIDTH(OPW), .NUM_OPCODES(NUMOP),
        .RUN_CNT_WIDTH(RCW), .RESET_CYCLES(RSTC), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .run_count(run_count), .mode(mode), .reset_dut_req(reset_dut_req),
        .dut_reset(dut_reset), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .shift_op(shift_op), .shift_dir(shift_dir),
        .shift_const(shift_const), .carry_in(carry_in),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [2:0]     sh;
        logic           dir;
        logic           cst;
        logic           cy;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } txn_t;

    txn_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          n_a0 = 0, n_a1 = 0, n_txn = 0;
    logic [31:0] m_a, m_b, m_c;
    logic        rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ TAPS;
        return n;
    endfunction

    function automatic logic [W-1:0] exp_operand(input logic [31:0] x, input logic [1:0] md);
        logic [1:0]   sel;
        logic [W-1:0] r;
        sel = x[31:30];
        r   = x[W-1:0];
        if (md == 2'b00) begin
            if (sel == 2'b00) return 8'h00;
            if (sel == 2'b11) return 8'h01;
            return r;
        end
        if (md == 2'b10) begin
            if (sel == 2'b00) return 8'h00;
            if (sel == 2'b01) return 8'hFF;
            if (sel == 2'b10) return 8'h80;
            return r;
        end
        return r;
    endfunction

    task automatic model_reseed();
        m_a = SEED;
        m_b = SEED ^ 32'h5A5A_5A5A;
        m_c = SEED ^ 32'hA5A5_A5A5;
    endtask

    // Advance the model by 'steps' field loads, queueing the first push_n
    task automatic model_issue(input int steps, input int push_n, input logic [1:0] md);
        txn_t        t;
        logic [OPW-1:0] raw;
        for (int i = 0; i < steps; i++) begin
            raw   = m_c[OPW-1:0];
            t.op  = (int'(raw) >= NUMOP) ? OPW'(int'(raw) - NUMOP) : raw;
            t.sh  = m_c[10:8];
            t.dir = m_c[12];
            t.cst = m_c[13];
            t.cy  = m_c[14];
            if (md == 2'b11) begin
                t.a = W'(1) << (i % W);
                t.b = ~t.a;
            end else begin
                t.a = exp_operand(m_a, md);
                t.b = exp_operand(m_b, md);
            end
            if (i < push_n) sb_q.push_back(t);
            m_a = lfsr_next(m_a);
            m_b = lfsr_next(m_b);
            m_c = lfsr_next(m_c);
        end
    endtask

    // Monitor: every accepted transaction is compared against the queue head
    always @(negedge clk) begin
        if (!reset && op_valid && op_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_txn", 32'(op_valid), 32'd0);
            end else begin
                txn_t e, g;
                e = sb_q.pop_front();
                g = '{op: opcode, sh: shift_op, dir: shift_dir, cst: shift_const,
                      cy: carry_in, a: operand_a, b: operand_b};
                check("txn_fields", 32'(g), 32'(e));
                check("opcode_range", 32'(int'(opcode) < NUMOP), 32'd1);
                n_txn++;
                if (operand_a == 8'h00) n_a0++;
                if (operand_a == 8'h01) n_a1++;
            end
        end
    end

    // Random ready driver, re-checked after the delay so the main flow can take over
    always @(posedge clk) begin
        if (rnd_ready) begin
            #3;
            if (rnd_ready) op_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input logic [1:0] md, input logic rreq);
        run_count     = RCW'(n);
        mode          = md;
        reset_dut_req = rreq;
        start         = 1'b1;
        cyc();
        start         = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (done) found = 1'b1;
            else cyc();
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        logic [OPW-1:0] snap_op;
        logic [W-1:0]   snap_a;

        model_reseed();
        cyc(); cyc(); cyc();
        check("rst_op_valid",  32'(op_valid), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_done",      32'(done), 32'd0);
        check("rst_dut_reset", 32'(dut_reset), 32'd0);
        check("rst_issued",    32'(issued_count), 32'd0);
        check("rst_operand_a", 32'(operand_a), 32'd0);
        reset = 1'b0;
        cyc();

        // Walking-one, 3 transactions, always ready
        op_ready = 1'b1;
        model_issue(3, 3, 2'b11);
        start_run(3, 2'b11, 1'b0);
        check("t1_valid_T1", 32'(op_valid), 32'd1);
        check("t1_busy_T1",  32'(busy), 32'd1);
        cyc(); cyc();
        check("t1_valid_T3", 32'(op_valid), 32'd1);
        cyc();
        check("t1_done_T4",   32'(done), 32'd1);
        check("t1_valid_T4",  32'(op_valid), 32'd0);
        check("t1_issued_T4", 32'(issued_count), 32'd3);
        cyc();
        check("t1_busy_T5", 32'(busy), 32'd0);
        check("t1_done_T5", 32'(done), 32'd0);

        // Walking-one, 10 transactions with a 5-cycle stall after 2
        model_issue(10, 10, 2'b11);
        start_run(10, 2'b11, 1'b0);
        cyc(); cyc();
        op_ready = 1'b0;
        snap_op  = opcode;
        snap_a   = operand_a;
        check("t2_stall_a", 32'(operand_a), 32'h04);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_stall_valid",  32'(op_valid), 32'd1);
            check("t2_stall_issued", 32'(issued_count), 32'd2);
            check("t2_stall_opcode", 32'(opcode), 32'(snap_op));
            check("t2_stall_opa",    32'(operand_a), 32'(snap_a));
        end
        op_ready = 1'b1;
        wait_done("t2_done", 30);
        check("t2_issued", 32'(issued_count), 32'd10);
        cyc();

        // Empty run
        start_run(0, 2'b00, 1'b0);
        check("t3_done_T1",   32'(done), 32'd1);
        check("t3_valid_T1",  32'(op_valid), 32'd0);
        check("t3_issued_T1", 32'(issued_count), 32'd0);
        cyc();
        check("t3_busy_T2", 32'(busy), 32'd0);

        // DUT reset phase ahead of a uniform run
        model_issue(2, 2, 2'b01);
        start_run(2, 2'b01, 1'b1);
        for (int i = 1; i <= RSTC; i++) begin
            check("t4_dut_reset", 32'(dut_reset), 32'd1);
            check("t4_valid_low", 32'(op_valid), 32'd0);
            cyc();
        end
        check("t4_valid_T5",     32'(op_valid), 32'd1);
        check("t4_dut_reset_T5", 32'(dut_reset), 32'd0);
        wait_done("t4_done", 20);
        cyc();

        // Extended corners, short run
        model_issue(16, 16, 2'b10);
        start_run(16, 2'b10, 1'b0);
        wait_done("t5b_done", 40);
        cyc();

        // Weighted, 4096 transactions, random ready
        n_a0 = 0; n_a1 = 0; n_txn = 0;
        model_issue(4096, 4096, 2'b00);
        rnd_ready = 1'b1;
        start_run(4096, 2'b00, 1'b0);
        wait_done("t5_done", 40000);
        rnd_ready = 1'b0;
        op_ready  = 1'b1;
        check("t5_count",    32'(n_txn), 32'd4096);
        check("t5_a0_share", 32'(n_a0 >= 880 && n_a0 <= 1180), 32'd1);
        check("t5_a1_share", 32'(n_a1 >= 880 && n_a1 <= 1180), 32'd1);
        cyc();

        // Abort after two handshakes
        model_issue(3, 2, 2'b01);
        start_run(10, 2'b01, 1'b0);
        cyc(); cyc();
        check("t6_issued_pre", 32'(issued_count), 32'd2);
        op_ready = 1'b0;
        abort    = 1'b1;
        cyc();
        abort = 1'b0;
        check("t6_abort_valid",  32'(op_valid), 32'd0);
        check("t6_abort_busy",   32'(busy), 32'd0);
        check("t6_abort_done",   32'(done), 32'd0);
        check("t6_abort_issued", 32'(issued_count), 32'd2);
        check("t6_abort_queue",  32'(sb_q.size()), 32'd0);
        cyc();
        check("t6_no_done", 32'(done), 32'd0);

        // Reset mid-run, then the first transaction must be the seed one
        op_ready = 1'b1;
        model_issue(3, 2, 2'b00);
        start_run(10, 2'b00, 1'b0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        check("t6r_valid",  32'(op_valid), 32'd0);
        check("t6r_busy",   32'(busy), 32'd0);
        check("t6r_done",   32'(done), 32'd0);
        check("t6r_issued", 32'(issued_count), 32'd0);
        reset = 1'b0;
        sb_q.delete();
        model_reseed();
        model_issue(1, 1, 2'b00);
        start_run(1, 2'b00, 1'b0);
        check("t6r_valid_T1", 32'(op_valid), 32'd1);
        wait_done("t6r_done_seen", 10);
        cyc();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_stim_gen.md
Name: alu_stim_gen

Overview:
- Synthesisable, parametrised ALU stimulus sequencer for the RojoBlaze verification environment; the hardware successor of the software random ALU tester.
- Issues a programmable number of ALU transactions (opcode, shift controls, carry, two operands) over a valid/ready handshake to the ALU driver/DUT.
- Supports an optional DUT reset phase and four operand-distribution modes.
- Deterministic: LFSR-based, so a golden model reproduces every transaction.

Parameters:
- OPERAND_WIDTH, 8, operand width in bits; legal range 1..32.
- OPCODE_WIDTH, 5, opcode field width.
- NUM_OPCODES, 24, legal opcode count; constraint 2^(OPCODE_WIDTH-1) <= NUM_OPCODES <= 2^OPCODE_WIDTH.
- RUN_CNT_WIDTH, 16, width of run_count and issued_count.
- RESET_CYCLES, 4, length in cycles of the dut_reset pulse; must be >= 1.
- SEED, 32'hACE1_2249, base LFSR seed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the run; effective at the next edge
- run_count  in  RUN_CNT_WIDTH  transactions to issue; sampled on start
- mode  in  2  00 weighted, 01 uniform, 10 extended corners, 11 walking-one
- reset_dut_req  in  1  sampled on start; 1 = run the reset phase first
- dut_reset  out  1  DUT reset request
- op_valid  out  1  transaction fields valid
- op_ready  in  1  consumer accepts the transaction
- opcode  out  OPCODE_WIDTH  ALU opcode
- shift_op  out  3  shift operation
- shift_dir  out  1  shift direction
- shift_const  out  1  shift fill constant
- carry_in  out  1  carry input
- operand_a  out  OPERAND_WIDTH  first operand
- operand_b  out  OPERAND_WIDTH  second operand
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- issued_count  out  RUN_CNT_WIDTH  handshakes completed in the current run

Behaviour:
- Reset: state IDLE; all outputs 0; LFSRs loaded as follows:
  - lfsr_a = SEED
  - lfsr_b = SEED ^ 32'h5A5A5A5A
  - lfsr_c = SEED ^ 32'hA5A5A5A5
  - any seed that evaluates to zero is replaced by 1.
- LFSR: 32-bit Galois, taps 32'h80200003, shift right. All three step together, exactly once per field load.
- FSM states and transitions:
  - IDLE: start=1 with run_count=0 -> DONE. With reset_dut_req=1 -> RST. Otherwise -> ISSUE, loading fields.
  - RST: dut_reset=1 for exactly RESET_CYCLES cycles, then -> ISSUE, loading fields.
  - ISSUE: op_valid=1. On op_valid&&op_ready: issued_count+1. If that was the last transaction -> DONE, otherwise load the next fields. While !op_ready, all fields are held stable.
  - DONE: done=1 for one cycle, op_valid=0, then -> IDLE.
- Latency: start at cycle T gives op_valid at T+1, or at T+1+RESET_CYCLES when the reset phase runs. After the final handshake, done is asserted the next cycle.
- On start, issued_count clears to 0. LFSRs are not reseeded by start; only reset reseeds them.
- Field mapping from the current state of lfsr_c:
  - raw opcode = [OPCODE_WIDTH-1:0]; if raw >= NUM_OPCODES, opcode = raw - NUM_OPCODES.
  - shift_op = [10:8], shift_dir = [12], shift_const = [13], carry_in = [14].
- Operand selector sel = lfsr_x[31:30]; random value r = lfsr_x[OPERAND_WIDTH-1:0].
  - Mode 00: sel 00 -> 0, 11 -> 1, otherwise r.
  - Mode 01: r.
  - Mode 10: 00 -> 0, 01 -> all ones, 10 -> MSB only, 11 -> r.
  - Mode 11: operand_a = 1 << (issued_count mod OPERAND_WIDTH); operand_b = ~operand_a. LFSRs still step.
- start while busy is ignored. mode and run_count are latched at start.
- abort in any non-IDLE state: -> IDLE at the next edge; op_valid and dut_reset drop; done is not pulsed; issued_count is held.
- reset mid-run behaves identically to power-on reset.
- op_ready while !op_valid has no effect. issued_count does not overflow because it is bounded by run_count.

Decomposition:
- Shared package kcpsmx3_inc carries OPERAND_WIDTH, opcode_t and shift_op_t.
- A new gen_mode_t enum (WEIGHTED, UNIFORM, CORNERS, WALKING) and the LFSR tap constant are added to kcpsmx3_inc.
- One sub-module, stim_lfsr32 (parameter SEED; step enable; 32-bit state out), instantiated three times.

Test Plan:
1. Mode 11, run_count=3, op_ready=1, start at T:
   - op_valid high T+1..T+3.
   - operand_a 8'h01, 8'h02, 8'h04; operand_b 8'hFE, 8'hFD, 8'hFB.
   - done at T+4; issued_count=3; busy low at T+5.
2. Mode 11, run_count=10: 9th operand_a wraps to 8'h01. Holding op_ready low 5 cycles mid-run: all fields stable, issued_count unchanged.
3. run_count=0: done at T+1; op_valid never asserted; issued_count=0.
4. reset_dut_req=1, RESET_CYCLES=4: dut_reset high T+1..T+4; op_valid first high at T+5.
5. Mode 00, 4096 runs, random op_ready:
   - every transaction matches the golden LFSR model bit-exactly.
   - every opcode < NUM_OPCODES.
   - operand_a==0 about 25% and ==1 about 25% of transactions.
6. abort or reset after 2 handshakes:
   - op_valid=0 and busy=0 the next cycle; no done pulse.
   - after reset, the first transaction equals the post-reset seed transaction.
